// File: rtl/lzc_pkg.sv
// lzc_pkg: shared types and helpers for the pipelined leading/trailing-zero counter.
package lzc_pkg;
    // Node count field is sized for operands up to 256 bits; each level only fills its low bits.
    localparam int LZC_CNT_MAX = 8;
    localparam int LZC_NODE_W  = LZC_CNT_MAX + 1;

    typedef enum logic {LZC_LEAD = 1'b0, LZC_TRAIL = 1'b1} lzc_mode_e;

    typedef struct packed {
        logic                   any;
        logic [LZC_CNT_MAX-1:0] cnt;
    } lzc_node_t;

    function automatic int lzc_count_w(int width);
        return $clog2(width) + 1;
    endfunction
endpackage

// File: rtl/lzc_merge.sv
// lzc_merge: one two-halves node of the zero-count tree at a given level.
module lzc_merge
    import lzc_pkg::*;
#(
    parameter int LEVEL = 1
) (
    input  logic [LZC_NODE_W-1:0] l,
    input  logic [LZC_NODE_W-1:0] r,
    output logic [LZC_NODE_W-1:0] o
);
    localparam logic [LZC_CNT_MAX-1:0] HALF = LZC_CNT_MAX'(1) << (LEVEL - 1);
    lzc_node_t a, b;
    assign a = l;
    assign b = r;
    assign o = {a.any | b.any, a.any ? a.cnt : (b.cnt | HALF)};
endmodule

// File: rtl/lzc_pipe.sv
// lzc_pipe: pipelined elastic LZ/TZ counter with valid/ready flow control.
// Defining LZC_PIPE_NORM_EN adds out_norm, the operand shifted by the count.
module lzc_pipe
    import lzc_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    input  logic                          in_mode,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [lzc_count_w(WIDTH)-1:0] out_count,
    output logic                          out_zero
`ifdef LZC_PIPE_NORM_EN
    ,
    output logic [WIDTH-1:0]              out_norm
`endif
);
    localparam int COUNT = lzc_count_w(WIDTH) - 1;

    function automatic int rank_of(int lvl);
        int k = 0;
        for (int r = 1; r < STAGES; r++)
            if ((r * COUNT + STAGES - 1) / STAGES == lvl) k = r;
        return k;
    endfunction

    if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0 || STAGES < 1 || STAGES > COUNT) begin : g_bad_cfg
        $fatal(1, "lzc_pipe: WIDTH must be a power of 2 >= 2 and STAGES in 1..log2(WIDTH)");
    end

    logic [STAGES:1]   vld, en;
    logic [STAGES+1:1] rdy;
    logic [WIDTH-1:0]  op;
    lzc_node_t         nd [1:2*WIDTH-1];
    lzc_node_t         nq [1:2*WIDTH-1];

    always_comb begin
        rdy[STAGES+1] = out_ready;
        for (int r = STAGES; r >= 1; r--) rdy[r] = ~vld[r] | rdy[r+1];
    end

    // en[r]: rank r captures the beat held by the rank (or input) just upstream
    assign en        = rdy[STAGES:1] & STAGES'({vld, in_valid});
    assign in_ready  = rst_n & rdy[1];
    assign out_valid = vld[STAGES];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) vld <= '0;
        else vld <= (rdy[STAGES:1] & STAGES'({vld, in_valid})) | (~rdy[STAGES:1] & vld);

    assign op = lzc_mode_e'(in_mode) == LZC_TRAIL ? {<<{in_data}} : in_data;

    // Heap-indexed tree: node i has children 2i and 2i+1, leaves at WIDTH..2*WIDTH-1 (MSB first)
    for (genvar i = 1; i < 2 * WIDTH; i++) begin : g_node
        localparam int LVL = COUNT - ($clog2(i + 1) - 1);
        localparam int RNK = rank_of(LVL);
        if (LVL == 0) begin : g_leaf
            assign nd[i] = '{any: op[2*WIDTH-1-i], cnt: '0};
        end else begin : g_merge
            lzc_merge #(.LEVEL(LVL)) u_merge (.l(nq[2*i]), .r(nq[2*i+1]), .o(nd[i]));
        end
        if (RNK != 0) begin : g_reg
            lzc_node_t q;
            always_ff @(posedge clk or negedge rst_n)
                if (!rst_n) q <= '0;
                else if (en[RNK]) q <= nd[i];
            assign nq[i] = q;
        end else begin : g_wire
            assign nq[i] = nd[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_count <= '0;
            out_zero  <= 1'b0;
        end else if (en[STAGES]) begin
            out_count <= nq[1].any ? (COUNT+1)'(nq[1].cnt) : (COUNT+1)'(WIDTH);
            out_zero  <= ~nq[1].any;
        end

`ifdef LZC_PIPE_NORM_EN
    logic [WIDTH:0] pd [STAGES];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            for (int r = 0; r < STAGES; r++) pd[r] <= '0;
        end else begin
            if (en[1]) pd[0] <= {in_mode, in_data};
            for (int r = 1; r < STAGES; r++) if (en[r+1]) pd[r] <= pd[r-1];
        end

    assign out_norm = pd[STAGES-1][WIDTH] ? pd[STAGES-1][WIDTH-1:0] >> out_count
                                          : pd[STAGES-1][WIDTH-1:0] << out_count;
`endif
endmodule
